// File: rtl/hdmi_clk_supervisor.sv
// hdmi_clk_supervisor
// Sequencer for the HDMI receive PLL, clocked by the system clock.
// It measures the incoming HDMI clock over fixed windows and enables the PLL
// only when the measured rate is plausible. It then waits for a stable lock
// before reporting ready, and drops the PLL again on lock loss or a bad clock.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_hdmi_div   asynchronous toggle derived from the HDMI clock
//   i_locked     asynchronous PLL lock indication
//   o_pll_ce     PLL enable (low powers down / resets the PLL)
//   o_ready      HDMI clocks stable and usable
//   o_lost       one-cycle pulse when leaving RUN
//   o_freq       edge count of the last completed window
//   o_freq_valid one-cycle pulse when o_freq updates
//   o_state      FSM state (IDLE=0, START=1, SETTLE=2, RUN=3)
module hdmi_clk_supervisor #(
  parameter int WINDOW_LG     = 20,
  parameter int MIN_EDGES     = 4096,
  parameter int MAX_EDGES     = 300000,
  parameter int LOCK_TIMEOUT  = 2000000,
  parameter int SETTLE_CYCLES = 65536
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_hdmi_div,
  input  logic                 i_locked,
  output logic                 o_pll_ce,
  output logic                 o_ready,
  output logic                 o_lost,
  output logic [WINDOW_LG-1:0] o_freq,
  output logic                 o_freq_valid,
  output logic [1:0]           o_state
);

  localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WINDOW_LG-1:0] MIN_C = WINDOW_LG'(MIN_EDGES);
  localparam logic [WINDOW_LG-1:0] MAX_C = WINDOW_LG'(MAX_EDGES);
  localparam logic [WINDOW_LG-1:0] W_ONE = WINDOW_LG'(1);
  // The timeout counter counts down to zero from LOCK_TIMEOUT-1, so the PLL
  // stays enabled for exactly LOCK_TIMEOUT cycles and the value always fits.
  localparam logic [TO_W-1:0]      TO_LOAD = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]      TO_ONE  = TO_W'(1);
  localparam logic [ST_W-1:0]      ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [ST_W-1:0]      ST_ONE  = ST_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  // Synchronisers: [0] is the first stage.
  logic [2:0] div_sync_q;
  logic [1:0] lock_sync_q;
  logic       edge_seen;
  logic       locked_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      div_sync_q  <= {div_sync_q[1:0], i_hdmi_div};
      lock_sync_q <= {lock_sync_q[0], i_locked};
    end
  end

  // Both edges of the divided clock count.
  assign edge_seen = div_sync_q[1] ^ div_sync_q[2];
  assign locked_s  = lock_sync_q[1];

  // Frequency measurement.
  logic [WINDOW_LG-1:0] win_q, win_d;
  logic [WINDOW_LG-1:0] edge_q, edge_d;
  logic [WINDOW_LG-1:0] freq_q, freq_d;
  logic                 freq_valid_q;
  logic                 eval_q;
  logic                 in_range_q;

  always_comb begin
    win_d  = win_q + W_ONE;
    edge_d = edge_q;
    freq_d = freq_q;
    if (edge_seen && (edge_q != '1)) begin
      edge_d = edge_q + W_ONE;
    end
    // On the wrap cycle the reported count includes an edge seen in that
    // same cycle, and counting restarts from zero for the next window.
    if (win_q == '1) begin
      freq_d = edge_d;
      edge_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_q        <= '0;
      edge_q       <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      eval_q       <= 1'b0;
      in_range_q   <= 1'b0;
    end else begin
      win_q        <= win_d;
      edge_q       <= edge_d;
      freq_q       <= freq_d;
      freq_valid_q <= (win_q == '1);
      // Range check is registered and consumed the cycle after the update.
      eval_q       <= freq_valid_q;
      in_range_q   <= (freq_q >= MIN_C) && (freq_q <= MAX_C);
    end
  end

  logic range_ok;
  logic range_bad;
  assign range_ok  = eval_q && in_range_q;
  assign range_bad = eval_q && !in_range_q;

  // Sequencer with registered outputs.
  state_t            state_q;
  logic              pll_ce_q;
  logic              ready_q;
  logic              lost_q;
  logic [TO_W-1:0]   to_q;
  logic [ST_W-1:0]   settle_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pll_ce_q <= 1'b0;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
      to_q     <= '0;
      settle_q <= '0;
    end else begin
      lost_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (range_ok) begin
            state_q  <= START;
            pll_ce_q <= 1'b1;
            to_q     <= TO_LOAD;
          end
        end
        START: begin
          if (range_bad) begin
            state_q  <= IDLE;
            pll_ce_q <= 1'b0;
          end else if (locked_s) begin
            state_q  <= SETTLE;
            settle_q <= '0;
          end else if (to_q == '0) begin
            state_q  <= IDLE;
            pll_ce_q <= 1'b0;
          end else begin
            to_q <= to_q - TO_ONE;
          end
        end
        SETTLE: begin
          if (!locked_s || range_bad) begin
            state_q  <= IDLE;
            pll_ce_q <= 1'b0;
          end else if (settle_q == ST_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            settle_q <= settle_q + ST_ONE;
          end
        end
        RUN: begin
          if (!locked_s || range_bad) begin
            state_q  <= IDLE;
            pll_ce_q <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_pll_ce     = pll_ce_q;
  assign o_ready      = ready_q;
  assign o_lost       = lost_q;
  assign o_freq       = freq_q;
  assign o_freq_valid = freq_valid_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_hdmi_clk_supervisor.sv
// Testbench for hdmi_clk_supervisor with a 1024-cycle measurement window.
module tb_hdmi_clk_supervisor;

  localparam int WLG  = 10;
  localparam int MINE = 64;
  localparam int MAXE = 400;
  localparam int LTO  = 2000;
  localparam int SETC = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           div;
  logic           locked;
  logic           pll_ce;
  logic           ready;
  logic           lost;
  logic [WLG-1:0] freq;
  logic           freq_valid;
  logic [1:0]     state;

  always #5 clk = ~clk;

  hdmi_clk_supervisor #(
    .WINDOW_LG    (WLG),
    .MIN_EDGES    (MINE),
    .MAX_EDGES    (MAXE),
    .LOCK_TIMEOUT (LTO),
    .SETTLE_CYCLES(SETC)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_hdmi_div  (div),
    .i_locked    (locked),
    .o_pll_ce    (pll_ce),
    .o_ready     (ready),
    .o_lost      (lost),
    .o_freq      (freq),
    .o_freq_valid(freq_valid),
    .o_state     (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // half_p > 0: toggle every half_p cycles (first toggle right after the
  // change); 0: hold level; < 0: force low.
  int half_p = -1;
  int last_p = -1;
  int gcnt   = 0;

  initial begin
    div = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (half_p != last_p) begin
        gcnt   = 0;
        last_p = half_p;
      end
      if (half_p < 0) begin
        div = 1'b0;
      end else if (half_p > 0) begin
        if (gcnt == 0) div = ~div;
        gcnt = (gcnt + 1 == half_p) ? 0 : gcnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where o_freq_valid is high; returns cycles taken.
  task automatic wait_valid(input string name, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!freq_valid && k < 3000);
    check(name, {31'd0, freq_valid}, 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, input string name);
    int k;
    k = 0;
    while (state != st && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, {30'd0, state}, {30'd0, st});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_ce"}, {31'd0, pll_ce}, 32'd0);
    check({tag, "_ready"},  {31'd0, ready},  32'd0);
    check({tag, "_lost"},   {31'd0, lost},   32'd0);
    check({tag, "_freq"},   {22'd0, freq},   32'd0);
    check({tag, "_valid"},  {31'd0, freq_valid}, 32'd0);
    check({tag, "_state"},  {30'd0, state},  32'd0);
  endtask

  typedef struct {
    int p;
    int exp_freq;
    int exp_state;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int hi;

    vecs[0] = '{0,  0,    0};  // no clock
    vecs[1] = '{4,  256,  1};  // nominal
    vecs[2] = '{8,  128,  1};
    vecs[3] = '{16, 64,   1};  // exactly MIN_EDGES
    vecs[4] = '{32, 32,   0};  // below MIN_EDGES
    vecs[5] = '{2,  512,  0};  // above MAX_EDGES
    vecs[6] = '{1,  1023, 0};  // 1024 edges saturate
    vecs[7] = '{4,  256,  1};

    rst    = 1'b1;
    locked = 1'b0;
    half_p = -1;
    step(5);
    check_reset_outputs("reset");

    // No clock for five windows.
    rst    = 1'b0;
    half_p = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("noclk_valid", k);
      check("noclk_freq", {22'd0, freq}, 32'd0);
      check("noclk_pll_ce", {31'd0, pll_ce}, 32'd0);
      check("noclk_state", {30'd0, state}, 32'd0);
      $display("noclk window %0d: freq=%0d state=%0d", i, freq, state);
    end

    // Table: settle one window on the new rate, check the next.
    for (int i = 0; i < 8; i++) begin
      half_p = vecs[i].p;
      wait_valid("vec_valid_a", k);
      wait_valid("vec_valid_b", k);
      check($sformatf("vec%0d_freq", i), {22'd0, freq}, vecs[i].exp_freq);
      step(2);
      check($sformatf("vec%0d_state", i), {30'd0, state}, vecs[i].exp_state);
      $display("vec %0d: half_p=%0d freq=%0d state=%0d", i, vecs[i].p, freq, state);
    end

    // Normal bring-up from a clean reset.
    rst    = 1'b1;
    half_p = -1;
    step(3);
    rst    = 1'b0;
    half_p = 4;
    wait_valid("bu_valid", k);
    check("bu_first_window", k, 1024);
    check("bu_freq", {22'd0, freq}, 32'd256);
    check("bu_pll_ce_at_valid", {31'd0, pll_ce}, 32'd0);
    step(1);
    check("bu_pll_ce_plus1", {31'd0, pll_ce}, 32'd0);
    step(1);
    check("bu_pll_ce_plus2", {31'd0, pll_ce}, 32'd1);
    check("bu_state_start", {30'd0, state}, 32'd1);
    step(100);
    locked = 1'b1;
    step(2);
    check("bu_state_before_settle", {30'd0, state}, 32'd1);
    step(1);
    check("bu_state_settle", {30'd0, state}, 32'd2);
    step(255);
    check("bu_ready_early", {31'd0, ready}, 32'd0);
    step(1);
    check("bu_ready", {31'd0, ready}, 32'd1);
    check("bu_state_run", {30'd0, state}, 32'd3);
    check("bu_pll_ce_run", {31'd0, pll_ce}, 32'd1);
    $display("bring-up: state=%0d ready=%0d", state, ready);

    // Lock loss in RUN.
    step(20);
    locked = 1'b0;
    step(2);
    check("ll_lost_early", {31'd0, lost}, 32'd0);
    check("ll_ready_early", {31'd0, ready}, 32'd1);
    step(1);
    check("ll_lost", {31'd0, lost}, 32'd1);
    check("ll_ready", {31'd0, ready}, 32'd0);
    check("ll_pll_ce", {31'd0, pll_ce}, 32'd0);
    check("ll_state", {30'd0, state}, 32'd0);
    step(1);
    check("ll_lost_pulse_end", {31'd0, lost}, 32'd0);
    $display("lock loss: lost pulse seen, state=%0d", state);

    // Lock timeout: PLL enabled for exactly LOCK_TIMEOUT cycles.
    k = 0;
    while (!pll_ce && k < 3000) begin
      step(1);
      k++;
    end
    check("to_rise", {31'd0, pll_ce}, 32'd1);
    hi = 0;
    while (pll_ce && hi < 5000) begin
      step(1);
      hi++;
    end
    check("to_high_cycles", hi, LTO);
    check("to_state_idle", {30'd0, state}, 32'd0);
    wait_valid("to_next_valid", k);
    check("to_pll_ce_at_valid", {31'd0, pll_ce}, 32'd0);
    step(2);
    check("to_pll_ce_reenable", {31'd0, pll_ce}, 32'd1);
    $display("timeout: pll_ce high for %0d cycles", hi);

    // Clock stops in RUN.
    locked = 1'b1;
    wait_state(2'd3, 600, "stop_reach_run");
    wait_valid("stop_valid_a", k);
    half_p = 0;
    wait_valid("stop_valid_b", k);
    check("stop_freq", {22'd0, freq}, 32'd0);
    step(1);
    check("stop_lost_early", {31'd0, lost}, 32'd0);
    check("stop_state_early", {30'd0, state}, 32'd3);
    step(1);
    check("stop_lost", {31'd0, lost}, 32'd1);
    check("stop_state", {30'd0, state}, 32'd0);
    check("stop_ready", {31'd0, ready}, 32'd0);
    $display("clock stop: freq=%0d state=%0d", freq, state);

    // Overspeed in RUN.
    half_p = 4;
    wait_state(2'd3, 5000, "over_reach_run");
    wait_valid("over_valid_a", k);
    half_p = 2;
    wait_valid("over_valid_b", k);
    n_cmp++;
    if (freq <= MAXE || freq > 512) begin
      n_bad++;
      $display("FAIL over_freq: got %0d, expected %0d..512", freq, MAXE + 1);
    end
    step(2);
    check("over_lost", {31'd0, lost}, 32'd1);
    check("over_state", {30'd0, state}, 32'd0);
    $display("overspeed: freq=%0d state=%0d", freq, state);

    // Reset pulse during SETTLE.
    half_p = 4;
    wait_state(2'd2, 3000, "rs_reach_settle");
    step(50);
    rst = 1'b1;
    step(1);
    check_reset_outputs("rs");
    rst = 1'b0;
    wait_valid("rs_valid", k);
    check("rs_window", k, 1024);
    check("rs_pll_ce_at_valid", {31'd0, pll_ce}, 32'd0);
    step(2);
    check("rs_state_start", {30'd0, state}, 32'd1);
    check("rs_pll_ce", {31'd0, pll_ce}, 32'd1);
    step(1);
    check("rs_state_settle", {30'd0, state}, 32'd2);
    $display("reset in settle: resumed, state=%0d", state);

    // One-cycle lock glitch during SETTLE.
    step(10);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    check("gl_state_hold", {30'd0, state}, 32'd2);
    step(1);
    check("gl_state_idle", {30'd0, state}, 32'd0);
    check("gl_pll_ce", {31'd0, pll_ce}, 32'd0);
    $display("glitch in settle: state=%0d", state);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
